// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   DEFAULT_RESET_PC : address of the first fetch after reset
//   DEFAULT_NOP_INST : bubble presented to decode when nothing valid is available
//   state_e          : fetch FSM encoding (2 bits)
//   align_word       : clears the byte-offset bits of an address
package if_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction memory bus: req/gnt address phase, rvalid/rdata response phase.
//   req    : fetch request valid (master -> memory)
//   addr   : fetch address, stable while req=1 and gnt=0
//   gnt    : memory accepts the request this cycle
//   rvalid : read data valid; there is no ready, the master must accept it
//   rdata  : instruction word
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_buf.sv
// if_buf: one-entry skid buffer holding a fetched {inst, addr} while decode stalls.
//   clk, rst           : clock, synchronous active-low reset
//   load               : capture load_inst/load_addr, mark valid
//   drain              : entry consumed by the output register
//   flush              : discard the entry (redirect); wins over load
//   valid, inst, addr  : buffered entry
module if_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_addr,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] addr
);

  always_ff @(posedge clk) begin
    if (!rst)        valid <= 1'b0;
    else if (flush)  valid <= 1'b0;
    else if (load)   valid <= 1'b1;
    else if (drain)  valid <= 1'b0;
  end

  // NOTE: the payload is deliberately not reset; valid qualifies it, so
  // its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (load) begin
      inst <= load_inst;
      addr <= load_addr;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage. Owns the PC, issues one read at a time to
// instruction memory and presents {inst, inst_addr, inst_valid} to decode.
//   clk, rst     : clock, synchronous active-low reset
//   imem         : instruction memory bus (master side)
//   jump_en_i    : redirect from execute; beats hold_i
//   jump_addr_i  : redirect target, low two bits ignored
//   hold_i       : decode stall; outputs freeze, a late response goes to the skid buffer
//   inst_o       : instruction to decode (NOP_INST when not valid)
//   inst_addr_o  : PC of inst_o
//   inst_valid_o : inst_o is a real fetched instruction
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic               clk,
  input  logic               rst,
  if_fetch_if.master         imem,
  input  logic               jump_en_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               hold_i,
  output logic [31:0]        inst_o,
  output logic [31:0]        inst_addr_o,
  output logic               inst_valid_o
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        kill_q, kill_d;

  logic        buf_valid;
  logic [31:0] buf_inst, buf_addr;
  logic        fire, resp_ok;

  // Requests stop while the skid buffer is full, so it can never overflow.
  assign imem.req  = (state_q == S_REQ) && !buf_valid;
  assign imem.addr = pc_q;
  assign fire      = imem.req && imem.gnt;
  // A response is usable only for the live outstanding request.
  assign resp_ok   = imem.rvalid && (state_q == S_WAIT) && !kill_q;

  // NOTE: every signal is given a default before the case so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    kill_d        = kill_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (fire) begin
          state_d       = S_WAIT;
          inflight_pc_d = pc_q;
          pc_d          = pc_q + 32'd4;
          // A grant coinciding with a redirect fetched the wrong path.
          if (jump_en_i) kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
        end else if (jump_en_i) begin
          kill_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (jump_en_i) pc_d = align_word(jump_addr_i);
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inst_o       <= NOP_INST;
      inst_addr_o  <= '0;
      inst_valid_o <= 1'b0;
    end else if (jump_en_i) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end else if (!hold_i) begin
      if (buf_valid) begin
        inst_o       <= buf_inst;
        inst_addr_o  <= buf_addr;
        inst_valid_o <= 1'b1;
      end else if (resp_ok) begin
        inst_o       <= imem.rdata;
        inst_addr_o  <= inflight_pc_q;
        inst_valid_o <= 1'b1;
      end else begin
        inst_o       <= NOP_INST;
        inst_valid_o <= 1'b0;
      end
    end
  end

  if_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_i && !jump_en_i && resp_ok),
    .drain     (!hold_i && !jump_en_i && buf_valid),
    .flush     (jump_en_i),
    .load_inst (imem.rdata),
    .load_addr (inflight_pc_q),
    .valid     (buf_valid),
    .inst      (buf_inst),
    .addr      (buf_addr)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch. Inputs change 1 ns after a rising edge;
// outputs are sampled at the same point, i.e. they reflect the last edge.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        hold = 1'b0;
  logic [31:0] inst, inst_addr;
  logic        inst_valid;

  int checks = 0;
  int errors = 0;

  if_fetch_if imem ();

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .hold_i       (hold),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_valid_o (inst_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    imem.gnt    = gnt;
    imem.rvalid = rvalid;
    imem.rdata  = rdata;
  endtask

  task automatic out(input string tag, input logic [31:0] i, input logic [31:0] a, input logic v);
    check({tag, ".inst"}, inst, i);
    check({tag, ".addr"}, inst_addr, a);
    check({tag, ".valid"}, {31'b0, inst_valid}, {31'b0, v});
  endtask

  task automatic bus(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".req"}, {31'b0, imem.req}, {31'b0, req});
    if (req) check({tag, ".raddr"}, imem.addr, addr);
  endtask

  initial begin
    mem(1'b0, 1'b0, '0);

    // Reset
    cyc(); cyc();
    out("rst", NOP, 32'h0, 1'b0);
    bus("rst", 1'b0, 32'h0);
    rst = 1'b1;

    // 1: idle cycle, first fetch, two-cycle latency
    cyc();
    bus("t1_req", 1'b1, 32'h8000_0000);
    mem(1'b1, 1'b0, '0);
    cyc();
    bus("t1_wait", 1'b0, 32'h0);
    out("t1_wait", NOP, 32'h0, 1'b0);
    mem(1'b0, 1'b1, 32'h0050_0093);
    cyc();
    out("t1_data", 32'h0050_0093, 32'h8000_0000, 1'b1);
    bus("t1_next", 1'b1, 32'h8000_0004);
    mem(1'b0, 1'b0, '0);

    // 2: no grant for 3 cycles, address held
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus("t2_stall", 1'b1, 32'h8000_0004);
    end
    out("t2_bubble", NOP, 32'h8000_0000, 1'b0);
    mem(1'b1, 1'b0, '0);
    cyc();
    mem(1'b0, 1'b1, 32'h0010_0193);
    cyc();
    out("t2_data", 32'h0010_0193, 32'h8000_0004, 1'b1);
    bus("t2_next", 1'b1, 32'h8000_0008);

    // 3: hold while the response returns -> skid buffer
    mem(1'b1, 1'b0, '0);
    hold = 1'b1;
    cyc();
    out("t3_frz0", 32'h0010_0193, 32'h8000_0004, 1'b1);
    mem(1'b0, 1'b1, 32'h00A0_0113);
    cyc();
    out("t3_frz1", 32'h0010_0193, 32'h8000_0004, 1'b1);
    bus("t3_buf", 1'b0, 32'h0);
    mem(1'b0, 1'b0, '0);
    cyc();
    out("t3_frz2", 32'h0010_0193, 32'h8000_0004, 1'b1);
    bus("t3_buf2", 1'b0, 32'h0);
    hold = 1'b0;
    cyc();
    out("t3_drain", 32'h00A0_0113, 32'h8000_0008, 1'b1);
    bus("t3_resume", 1'b1, 32'h8000_000C);

    // 4: redirect in S_WAIT, late response dropped
    mem(1'b1, 1'b0, '0);
    cyc();
    mem(1'b0, 1'b0, '0);
    jump_en = 1'b1;
    jump_addr = 32'h8000_0101;
    cyc();
    out("t4_jump", NOP, 32'h8000_0008, 1'b0);
    jump_en = 1'b0;
    mem(1'b0, 1'b1, 32'hDEAD_BEEF);
    cyc();
    out("t4_drop", NOP, 32'h8000_0008, 1'b0);
    bus("t4_tgt", 1'b1, 32'h8000_0100);
    mem(1'b1, 1'b0, '0);
    cyc();
    mem(1'b0, 1'b1, 32'h0030_0213);
    cyc();
    out("t4_data", 32'h0030_0213, 32'h8000_0100, 1'b1);
    bus("t4_next", 1'b1, 32'h8000_0104);

    // 5: jump and hold together with a full buffer
    mem(1'b1, 1'b0, '0);
    hold = 1'b1;
    cyc();
    mem(1'b0, 1'b1, 32'h1111_1111);
    cyc();
    bus("t5_full", 1'b0, 32'h0);
    mem(1'b0, 1'b0, '0);
    jump_en = 1'b1;
    jump_addr = 32'h8000_0200;
    cyc();
    out("t5_flush", NOP, 32'h8000_0100, 1'b0);
    bus("t5_tgt", 1'b1, 32'h8000_0200);
    jump_en = 1'b0;
    hold = 1'b0;
    cyc();
    out("t5_empty", NOP, 32'h8000_0100, 1'b0);

    // 5b: redirect in the same cycle as a grant -> granted fetch is stale
    mem(1'b1, 1'b0, '0);
    jump_en = 1'b1;
    jump_addr = 32'h8000_0300;
    cyc();
    bus("t5b_wait", 1'b0, 32'h0);
    jump_en = 1'b0;
    mem(1'b0, 1'b1, 32'hBAD0_0BAD);
    cyc();
    out("t5b_drop", NOP, 32'h8000_0100, 1'b0);
    bus("t5b_tgt", 1'b1, 32'h8000_0300);

    // 6: PC wrap, then reset in S_WAIT
    mem(1'b0, 1'b0, '0);
    jump_en = 1'b1;
    jump_addr = 32'hFFFF_FFFF;
    cyc();
    bus("t6_top", 1'b1, 32'hFFFF_FFFC);
    jump_en = 1'b0;
    mem(1'b1, 1'b0, '0);
    cyc();
    mem(1'b0, 1'b1, 32'h0070_0393);
    cyc();
    out("t6_data", 32'h0070_0393, 32'hFFFF_FFFC, 1'b1);
    bus("t6_wrap", 1'b1, 32'h0000_0000);
    mem(1'b1, 1'b0, '0);
    cyc();
    mem(1'b0, 1'b0, '0);
    rst = 1'b0;
    cyc();
    out("t6_rst", NOP, 32'h0, 1'b0);
    bus("t6_rst", 1'b0, 32'h0);
    rst = 1'b1;
    cyc();
    bus("t6_idle", 1'b1, 32'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
